// File: rtl/hazard_ctrl_fsm_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encodings and default field geometry.
package hazard_ctrl_fsm_pkg;

    localparam int WORD_SIZE  = 16;
    localparam int RS_LSB_DEF = 10;
    localparam int RT_LSB_DEF = 8;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_FLUSH    = 2'd1,
        HZ_MEM_WAIT = 2'd2
    } hz_state_e;

endpackage

// File: rtl/hazard_sat_counter.sv
// 16-bit saturating event counter (async active-high clear), only built with HAZARD_STATS_EN.
// Latency: count reflects en one cycle later; no backpressure, holds at all-ones once saturated.
`ifdef HAZARD_STATS_EN
module hazard_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule
`endif

// File: rtl/hazard_ctrl_fsm.sv
// Pipeline hazard controller: load-use stall, mispredict IF flush window, data-memory freeze.
// Latency: Stall/Flush_IF/Freeze are Mealy, asserted in the same cycle as their cause.
// Backpressure: Freeze holds the whole pipe; HAZARD_STATS_EN adds saturating activity counters.
module hazard_ctrl_fsm
    import hazard_ctrl_fsm_pkg::*;
#(
    parameter int WORD_W       = WORD_SIZE,
    parameter int REG_ADDR_W   = 2,
    parameter int RS_LSB       = RS_LSB_DEF,
    parameter int RT_LSB       = RT_LSB_DEF,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WORD_W-1:0]     inst_ID,
    input  logic                  valid_ID,
    input  logic [REG_ADDR_W-1:0] rt_EX,
    input  logic                  memRead_EX,
    input  logic                  resolve_EX,
    input  logic [WORD_W-1:0]     realPC,
    input  logic [WORD_W-1:0]     predPC,
    input  logic                  memReq_MEM,
    input  logic                  memReady,
    output logic                  Stall,
    output logic                  Flush_IF,
    output logic                  Freeze,
    output logic                  busy
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0]           stall_cnt,
    output logic [15:0]           flush_cnt,
    output logic [15:0]           freeze_cnt
`endif
);

    localparam int FCNT_W = $clog2(FLUSH_CYCLES) + 1;

    hz_state_e             state, ret_state, eff_state;
    logic [FCNT_W-1:0]     fcnt;
    logic [REG_ADDR_W-1:0] rs_id, rt_id;
    logic                  lu, mp, mw;
    logic                  stall_c, flush_c, freeze_c;
    logic                  unused_inst;

    assign rs_id       = inst_ID[RS_LSB +: REG_ADDR_W];
    assign rt_id       = inst_ID[RT_LSB +: REG_ADDR_W];
    assign unused_inst = ^inst_ID;

    assign lu = memRead_EX & valid_ID & ((rs_id == rt_EX) | (rt_id == rt_EX));
    assign mp = resolve_EX & valid_ID & (realPC != predPC);
    assign mw = memReq_MEM & ~memReady;

    // The memReady cycle of MEM_WAIT already runs the rules of the state being resumed.
    always_comb begin
        eff_state = state;
        if ((state == HZ_MEM_WAIT) && memReady) begin
            eff_state = ret_state;
        end
    end

    always_comb begin
        stall_c  = 1'b0;
        flush_c  = 1'b0;
        freeze_c = 1'b0;
        unique case (eff_state)
            HZ_MEM_WAIT: freeze_c = 1'b1;
            HZ_FLUSH: begin
                if (mw) freeze_c = 1'b1;
                else    flush_c  = 1'b1;
            end
            default: begin
                if (mw)      freeze_c = 1'b1;
                else if (mp) flush_c  = 1'b1;
                else if (lu) stall_c  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= HZ_RUN;
            ret_state <= HZ_RUN;
            fcnt      <= '0;
        end else begin
            unique case (eff_state)
                HZ_MEM_WAIT: ;
                HZ_FLUSH: begin
                    if (mw) begin
                        state     <= HZ_MEM_WAIT;
                        ret_state <= HZ_FLUSH;
                    end else if (fcnt == '0) begin
                        state <= HZ_RUN;
                    end else begin
                        state <= HZ_FLUSH;
                        fcnt  <= fcnt - 1'b1;
                    end
                end
                default: begin
                    if (mw) begin
                        state     <= HZ_MEM_WAIT;
                        ret_state <= HZ_RUN;
                    end else if (mp && (FLUSH_CYCLES > 1)) begin
                        // First flush cycle is this one; FLUSH covers the remaining FLUSH_CYCLES-1.
                        state <= HZ_FLUSH;
                        fcnt  <= FCNT_W'(FLUSH_CYCLES - 2);
                    end else begin
                        state <= HZ_RUN;
                    end
                end
            endcase
        end
    end

    assign Stall    = stall_c  & ~reset;
    assign Flush_IF = flush_c  & ~reset;
    assign Freeze   = freeze_c & ~reset;
    assign busy     = (state != HZ_RUN) & ~reset;

`ifdef HAZARD_STATS_EN
    hazard_sat_counter #(.W(16)) u_stall_cnt (
        .clk(clk), .reset(reset), .en(Stall), .count(stall_cnt)
    );
    hazard_sat_counter #(.W(16)) u_flush_cnt (
        .clk(clk), .reset(reset), .en(Flush_IF), .count(flush_cnt)
    );
    hazard_sat_counter #(.W(16)) u_freeze_cnt (
        .clk(clk), .reset(reset), .en(Freeze), .count(freeze_cnt)
    );
`endif

endmodule
